// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single 32-bit ALU.
// One transaction in flight: IDLE accepts, EXEC computes, RESP holds the result until consumed.

module alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o,
  output logic        illegal_o
);
  logic        sub_s;
  logic        arith_s;
  logic        ovf_s;
  logic [31:0] b_eff_s;
  logic [32:0] sum_s;

  // Shared adder for ADD/SUB/SLT; flags are {Z,N,C,V}, C/V only meaningful for ADD/SUB.
  always_comb begin
    sub_s     = (op_i == 4'b0001) || (op_i == 4'b0101);
    b_eff_s   = sub_s ? ~b_i : b_i;
    sum_s     = {1'b0, a_i} + {1'b0, b_eff_s} + {32'd0, sub_s};
    ovf_s     = (a_i[31] == b_eff_s[31]) && (sum_s[31] != a_i[31]);
    arith_s   = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      4'b0000: begin result_o = sum_s[31:0]; arith_s = 1'b1; end
      4'b0001: begin result_o = sum_s[31:0]; arith_s = 1'b1; end
      4'b0010: result_o = a_i & b_i;
      4'b0011: result_o = a_i | b_i;
      4'b0100: result_o = a_i << b_i[4:0];
      4'b0101: result_o = {31'd0, sum_s[31] ^ ovf_s};
      4'b0110: result_o = a_i ^ b_i;
      4'b0111: result_o = a_i >> b_i[4:0];
      4'b1000: result_o = {31'd0, (a_i < b_i)};
      4'b1111: result_o = $signed(a_i) >>> b_i[4:0];
      default: begin result_o = 32'd0; illegal_o = 1'b1; end
    endcase
    if (illegal_o) begin
      flags_o = 4'b0000;
    end else begin
      flags_o = {(result_o == 32'd0), result_o[31], arith_s & sum_s[32], arith_s & ovf_s};
    end
  end
endmodule

module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req0_op,
  input  logic [3:0]        req1_op,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q;
  logic        prio_q;
  logic        owner_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  op_q;
  logic [31:0] result_q;
  logic [3:0]  flags_q;
  logic        err_q;
  logic        busy_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;

  logic        idle_s;
  logic        gnt0_s;
  logic        gnt1_s;
  logic        rsp_hs_s;
  logic [31:0] alu_result_s;
  logic [3:0]  alu_flags_s;
  logic        alu_illegal_s;

  alu u_alu (
    .a_i       (a_q),
    .b_i       (b_q),
    .op_i      (op_q),
    .result_o  (alu_result_s),
    .flags_o   (alu_flags_s),
    .illegal_o (alu_illegal_s)
  );

  // Grant logic: prio_q=1 means requester 1 wins a tie; ready is gated by reset so it reads 0 in reset.
  always_comb begin
    idle_s   = rst_n && (state_q == IDLE);
    gnt1_s   = idle_s && req1_valid && (!req0_valid || prio_q);
    gnt0_s   = idle_s && req0_valid && !gnt1_s;
    rsp_hs_s = owner_q ? rsp1_ready : rsp0_ready;
  end

  // Sequencer: capture on grant, latch ALU output in EXEC, hold response until the owner consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      op_q         <= 4'd0;
      result_q     <= 32'd0;
      flags_q      <= 4'd0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0_s || gnt1_s) begin
            a_q     <= gnt1_s ? req1_a  : req0_a;
            b_q     <= gnt1_s ? req1_b  : req0_b;
            op_q    <= gnt1_s ? req1_op : req0_op;
            owner_q <= gnt1_s;
            prio_q  <= !gnt1_s;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= alu_illegal_s ? 32'd0 : alu_result_s;
          flags_q      <= alu_illegal_s ? 4'd0  : alu_flags_s;
          err_q        <= alu_illegal_s;
          rsp0_valid_q <= !owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_hs_s) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: hand-computed results, latency, backpressure and round-robin order.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 32'd0, req1_a = 32'd0, req0_b = 32'd0, req1_b = 32'd0;
  logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  // One transaction from requester id; called and returns just after a rising edge.
  task automatic txn(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                     input int stall, input logic [31:0] exp_r, input logic [3:0] fmask,
                     input logic [3:0] exp_f, input logic exp_e);
    int lat;
    logic own_v, oth_v;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req(id, 1'b1, a, b, op);
    @(negedge clk);
    check_eq("accept_ready", (id == 0) ? req0_ready : req1_ready, 1'b1);
    check_eq("accept_other_ready", (id == 0) ? req1_ready : req0_ready, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    set_req(id, 1'b0, 32'd0, 32'd0, 4'd0);
    lat = 1;
    @(negedge clk);
    own_v = (id == 0) ? rsp0_valid : rsp1_valid;
    while (!own_v && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
      own_v = (id == 0) ? rsp0_valid : rsp1_valid;
    end
    check_eq("latency", lat, 2);
    check_eq("result", rsp_result, exp_r);
    check_eq("flags", {28'd0, rsp_flags & fmask}, {28'd0, exp_f});
    check_eq("err", rsp_err, exp_e);
    check_eq("resp_busy", busy, 1'b1);
    if (id == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      own_v = (id == 0) ? rsp0_valid : rsp1_valid;
      oth_v = (id == 0) ? rsp1_valid : rsp0_valid;
      check_eq("hold_valid", own_v, 1'b1);
      check_eq("hold_result", rsp_result, exp_r);
      check_eq("hold_flags", {28'd0, rsp_flags & fmask}, {28'd0, exp_f});
      check_eq("other_valid", oth_v, 1'b0);
    end
    if (id == 0) begin rsp0_ready = 1'b1; rsp1_ready = 1'b0; end
    else begin rsp1_ready = 1'b1; rsp0_ready = 1'b0; end
    @(posedge clk); #1;
    check_eq("handshake_drop", (id == 0) ? rsp0_valid : rsp1_valid, 1'b0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", {busy, rsp0_valid, rsp1_valid, rsp_err, req0_ready, req1_ready}, 6'd0);
    check_eq("reset_result", rsp_result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD, then back-to-back illegal op and SLTU (accept in the cycle after handshake)
    txn(0, 32'h00000005, 32'h00000003, 4'b0000, 0, 32'h00000008, 4'b1111, 4'b0000, 1'b0);
    txn(0, 32'h12345678, 32'h00000001, 4'b1010, 0, 32'h00000000, 4'b1111, 4'b0000, 1'b1);
    txn(0, 32'h00000005, 32'h00000010, 4'b1000, 0, 32'h00000001, 4'b1100, 4'b0000, 1'b0);
    // SLL with the non-owner's ready high for two cycles
    txn(0, 32'h00000001, 32'h00000002, 4'b0100, 2, 32'h00000004, 4'b1100, 4'b0000, 1'b0);
    // SUB going negative, four cycles of backpressure
    txn(1, 32'h00000005, 32'h0000000A, 4'b0001, 4, 32'hFFFFFFFB, 4'b1100, 4'b0100, 1'b0);

    // Round robin: both requesters valid continuously
    set_req(0, 1'b1, 32'h00000000, 32'h00000000, 4'b0000);
    set_req(1, 1'b1, 32'h80000010, 32'h00000002, 4'b1111);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check_eq("rr_gnt0", req0_ready, (g % 2 == 0) ? 1'b1 : 1'b0);
      check_eq("rr_gnt1", req1_ready, (g % 2 == 1) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rr_exec", {busy, req0_ready, req1_ready}, 3'b100);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rr_rsp_valid", {rsp0_valid, rsp1_valid}, (g % 2 == 0) ? 2'b10 : 2'b01);
      check_eq("rr_result", rsp_result, (g % 2 == 0) ? 32'h00000000 : 32'hE0000004);
      check_eq("rr_zn", {30'd0, rsp_flags[3:2]}, (g % 2 == 0) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset in the middle of EXEC drops everything
    set_req(0, 1'b1, 32'h00000005, 32'h00000003, 4'b0000);
    @(negedge clk);
    check_eq("pre_reset_accept", req0_ready, 1'b1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    check_eq("pre_reset_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midreset_outs", {busy, rsp0_valid, rsp1_valid, rsp_err, req0_ready, req1_ready}, 6'd0);
    check_eq("midreset_result", rsp_result, 32'd0);
    check_eq("midreset_flags", rsp_flags, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_eq("post_reset_idle", {busy, rsp0_valid, rsp1_valid}, 3'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
